// File: rtl/rst_seq_pkg.sv
// Shared types and helpers for the reset sequencer: FSM state encoding,
// reset-cause codes and a max() used to size the shared counter.
package rst_seq_pkg;

  typedef enum logic [1:0] {
    SYNC    = 2'd0,
    HOLD    = 2'd1,
    RELEASE = 2'd2,
    RUN     = 2'd3
  } state_e;

  localparam logic CAUSE_PAD = 1'b0;
  localparam logic CAUSE_SW  = 1'b1;

  function automatic int max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/rst_sync2.sv
// Two-flop reset synchronizer: asserts asynchronously with rst_n_i,
// deasserts synchronously to clk_i two edges after rst_n_i rises.
module rst_sync2 (
  input  logic clk_i,
  input  logic rst_n_i,
  output logic q_o
);

  logic [1:0] sync_q;
  logic [1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[0], 1'b1};
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) sync_q <= 2'b00;
    else          sync_q <= sync_d;
  end

  assign q_o = sync_q[1];

endmodule

// File: rtl/rst_sequencer.sv
// Stretched, staggered reset release for the Wishbone system and its peripherals.
// Optional macro SW_RST_EN: lets sw_rst_req_i restart the sequence from RUN.
//
// state   | meaning
// SYNC    | waiting for the synchronized pad reset to release
// HOLD    | wb_rst_o held for STRETCH cycles
// RELEASE | peripheral resets cleared LSB first, STAGE_GAP cycles apart
// RUN     | all resets released, rst_done_o high
module rst_sequencer
  import rst_seq_pkg::*;
#(
  parameter int STRETCH   = 16,
  parameter int N_STAGES  = 3,
  parameter int STAGE_GAP = 4
) (
  input  logic                wb_clk_i,
  input  logic                rst_n_pad_i,
  input  logic                sw_rst_req_i,
  output logic                wb_rst_o,
  output logic [N_STAGES-1:0] periph_rst_o,
  output logic                rst_done_o,
  output logic                rst_cause_o
);

  localparam int CNT_W = $clog2(max(STRETCH, STAGE_GAP)) + 1;
  localparam int IDX_W = $clog2(N_STAGES) + 1;

  localparam logic [CNT_W-1:0]    HOLD_LAST = CNT_W'(STRETCH - 1);
  localparam logic [CNT_W-1:0]    GAP_LAST  = CNT_W'(STAGE_GAP - 1);
  localparam logic [IDX_W-1:0]    IDX_LAST  = IDX_W'(N_STAGES - 1);
  localparam logic [N_STAGES-1:0] STAGE_ONE = N_STAGES'(1);

  logic pad_sync;

  rst_sync2 u_rst_sync2 (
    .clk_i   (wb_clk_i),
    .rst_n_i (rst_n_pad_i),
    .q_o     (pad_sync)
  );

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  wb_rst_q, wb_rst_d;
  logic [N_STAGES-1:0]   periph_rst_q, periph_rst_d;
  logic                  done_q, done_d;
`ifdef SW_RST_EN
  logic                  cause_q, cause_d;
`endif

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    wb_rst_d     = wb_rst_q;
    periph_rst_d = periph_rst_q;
    done_d       = done_q;
`ifdef SW_RST_EN
    cause_d      = cause_q;
`endif
    case (state_q)
      SYNC: begin
        if (pad_sync) begin
          state_d = HOLD;
          cnt_d   = '0;
        end
      end
      HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          state_d  = RELEASE;
          cnt_d    = '0;
          idx_d    = '0;
          wb_rst_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RELEASE: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d        = '0;
          periph_rst_d = periph_rst_q & ~(STAGE_ONE << idx_q);
          if (idx_q == IDX_LAST) begin
            state_d = RUN;
            done_d  = 1'b1;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RUN: begin
`ifdef SW_RST_EN
        // Software reset skips SYNC: the clock and pad are already known good.
        if (sw_rst_req_i) begin
          state_d      = HOLD;
          cnt_d        = '0;
          idx_d        = '0;
          wb_rst_d     = 1'b1;
          periph_rst_d = '1;
          done_d       = 1'b0;
          cause_d      = CAUSE_SW;
        end
`endif
      end
      default: state_d = SYNC;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge rst_n_pad_i) begin
    if (!rst_n_pad_i) begin
      state_q      <= SYNC;
      cnt_q        <= '0;
      idx_q        <= '0;
      wb_rst_q     <= 1'b1;
      periph_rst_q <= '1;
      done_q       <= 1'b0;
`ifdef SW_RST_EN
      cause_q      <= CAUSE_PAD;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      wb_rst_q     <= wb_rst_d;
      periph_rst_q <= periph_rst_d;
      done_q       <= done_d;
`ifdef SW_RST_EN
      cause_q      <= cause_d;
`endif
    end
  end

  assign wb_rst_o     = wb_rst_q;
  assign periph_rst_o = periph_rst_q;
  assign rst_done_o   = done_q;

`ifdef SW_RST_EN
  assign rst_cause_o = cause_q;
`else
  logic unused_sw_rst_req;
  assign unused_sw_rst_req = sw_rst_req_i;
  assign rst_cause_o       = CAUSE_PAD;
`endif

endmodule
